// File: rtl/fft_pingpong_ram_if.sv
// Acquisition and FFT-engine side signals of the ping-pong frame buffer.
// Signal names follow the block's external pin names.
interface fft_pingpong_ram_if #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_BITS  = 10
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  frame_ready;
  logic                  frame_done;
  logic [ADDR_BITS-1:0]  addrB;
  logic [DATA_WIDTH-1:0] DinB;
  logic                  write_enableB;
  logic [DATA_WIDTH-1:0] DoutB;
  logic                  fill_bank;
  logic                  overflow;

  modport master (
    output in_valid, in_data, frame_done, addrB, DinB, write_enableB,
    input  in_ready, frame_ready, DoutB, fill_bank, overflow
  );

  modport slave (
    input  in_valid, in_data, frame_done, addrB, DinB, write_enableB,
    output in_ready, frame_ready, DoutB, fill_bank, overflow
  );
endinterface

// File: rtl/fft_pingpong_ram.sv
// Two-bank ping-pong frame RAM: port A fills one bank, port B (1-cycle read) serves the other.
// in_ready drops only when both banks are full; BIT_REVERSE_WR_EN makes port A write bit-reversed.
module fft_pingpong_ram #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_BITS  = 10
) (
  input logic               Clk,
  input logic               reset,
  fft_pingpong_ram_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {S_FILL, S_FILL_BUSY, S_STALL} state_t;

  state_t                state, next_state;
  logic                  fill_bank, next_fill_bank;
  logic [ADDR_BITS-1:0]  wr_ptr;
  logic [ADDR_BITS-1:0]  wr_addr;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] dout;
  logic                  accept, last, eng_we;

  // Bank index is the MSB of the flat array address.
  logic [DATA_WIDTH-1:0] mem [0:2*DEPTH-1];

  assign bus.in_ready    = (state != S_STALL);
  assign bus.frame_ready = (state != S_FILL);
  assign bus.fill_bank   = fill_bank;
  assign bus.overflow    = overflow;
  assign bus.DoutB       = dout;

  assign accept = bus.in_valid && bus.in_ready;
  assign last   = accept && (&wr_ptr);
  assign eng_we = bus.write_enableB && bus.frame_ready;

`ifdef BIT_REVERSE_WR_EN
  always_comb begin
    wr_addr = '0;
    for (int i = 0; i < ADDR_BITS; i++) begin
      wr_addr[i] = wr_ptr[ADDR_BITS-1-i];
    end
  end
`else
  assign wr_addr = wr_ptr;
`endif

  always_comb begin
    next_state     = state;
    next_fill_bank = fill_bank;
    case (state)
      S_FILL: begin
        if (last) begin
          next_fill_bank = ~fill_bank;
          next_state     = S_FILL_BUSY;
        end
      end
      S_FILL_BUSY: begin
        if (last && bus.frame_done) begin
          next_fill_bank = ~fill_bank;
        end else if (bus.frame_done) begin
          next_state = S_FILL;
        end else if (last) begin
          next_state = S_STALL;
        end
      end
      S_STALL: begin
        if (bus.frame_done) begin
          next_fill_bank = ~fill_bank;
          next_state     = S_FILL_BUSY;
        end
      end
      default: next_state = S_FILL;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state     <= S_FILL;
      fill_bank <= 1'b0;
      wr_ptr    <= '0;
      overflow  <= 1'b0;
      dout      <= '0;
    end else begin
      state     <= next_state;
      fill_bank <= next_fill_bank;
      if (accept) wr_ptr <= wr_ptr + ADDR_BITS'(1);
      if (bus.in_valid && !bus.in_ready) overflow <= 1'b1;
      // Uses the pre-edge fill_bank, so a swap cycle still reads the old compute bank.
      dout <= mem[{~fill_bank, bus.addrB}];
    end
  end

  // Contents survive reset; the banks never coincide, so both writes are independent.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      if (accept) mem[{fill_bank, wr_addr}] <= bus.in_data;
      if (eng_we) mem[{~fill_bank, bus.addrB}] <= bus.DinB;
    end
  end
endmodule

// File: tb/tb_fft_pingpong_ram.sv
// Directed bench for fft_pingpong_ram (ADDR_BITS=3); expectations queued with a due cycle, checked by a monitor.
module tb_fft_pingpong_ram;
  localparam int DW = 18;
  localparam int AB = 3;
`ifdef BIT_REVERSE_WR_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  localparam int K_DOUT = 0, K_FR = 1, K_FB = 2, K_IR = 3, K_OV = 4;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  chk_t sb[$];

  fft_pingpong_ram_if #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) bus ();

  fft_pingpong_ram #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) dut (
    .Clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      c = sb.pop_front();
      case (c.kind)
        K_DOUT:  act = 32'(bus.DoutB);
        K_FR:    act = 32'(bus.frame_ready);
        K_FB:    act = 32'(bus.fill_bank);
        K_IR:    act = 32'(bus.in_ready);
        default: act = 32'(bus.overflow);
      endcase
      n_tests++;
      if (c.due != cyc || act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %0h expected %0h (due %0d, at %0d)", c.name, act, c.exp, c.due, cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int kind, input logic [31:0] exp, input string name);
    sb.push_back('{cyc, kind, exp, name});
  endtask

  task automatic send(input logic [DW-1:0] d, input logic done);
    bus.in_valid   = 1'b1;
    bus.in_data    = d;
    bus.frame_done = done;
    step();
    bus.in_valid   = 1'b0;
    bus.frame_done = 1'b0;
  endtask

  task automatic pulse_done();
    bus.frame_done = 1'b1;
    step();
    bus.frame_done = 1'b0;
  endtask

  task automatic read(input logic [AB-1:0] a);
    bus.addrB = a;
    step();
  endtask

  task automatic eng_write(input logic [AB-1:0] a, input logic [DW-1:0] d);
    bus.addrB         = a;
    bus.DinB          = d;
    bus.write_enableB = 1'b1;
    step();
    bus.write_enableB = 1'b0;
  endtask

  initial begin
    bus.in_valid      = 1'b0;
    bus.in_data       = '0;
    bus.frame_done    = 1'b0;
    bus.addrB         = '0;
    bus.DinB          = '0;
    bus.write_enableB = 1'b0;

    // Reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk(K_FR, 0, "rst_frame_ready");
    chk(K_FB, 0, "rst_fill_bank");
    chk(K_IR, 1, "rst_in_ready");
    chk(K_OV, 0, "rst_overflow");
    chk(K_DOUT, 0, "rst_doutb");

    // First frame 0..7 into bank 0
    for (int i = 0; i < 7; i++) send(DW'(i), 1'b0);
    chk(K_FR, 0, "fill7_frame_ready");
    chk(K_FB, 0, "fill7_fill_bank");
    send(DW'(7), 1'b0);
    chk(K_FR, 1, "fill8_frame_ready");
    chk(K_FB, 1, "fill8_fill_bank");
    chk(K_IR, 1, "fill8_in_ready");
    n_tests++;
    if (bus.frame_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL direct_fill8_frame_ready: got %0b", bus.frame_ready);
    end
    read(3'd5);
    chk(K_DOUT, 5, "read_addr5");
    read(3'd1);
    chk(K_DOUT, REV ? 32'd4 : 32'd1, "read_addr1");

    // Engine write while frame held; write cycle returns the old word
    eng_write(3'd2, 18'h3FFFF);
    chk(K_DOUT, 2, "engwr_old_value");
    step();
    chk(K_DOUT, 32'h3FFFF, "engwr_readback");

    // Same-address read/write
    eng_write(3'd3, 18'h000AA);
    chk(K_DOUT, REV ? 32'd6 : 32'd3, "rbw_old_value");
    step();
    chk(K_DOUT, 32'hAA, "rbw_new_value");

    // Fill bank 1 without release -> stall, drop, overflow
    for (int i = 0; i < 7; i++) send(DW'(10 + i), 1'b0);
    send(DW'(17), 1'b0);
    chk(K_IR, 0, "stall_in_ready");
    chk(K_FB, 1, "stall_fill_bank");
    chk(K_FR, 1, "stall_frame_ready");
    chk(K_OV, 0, "stall_no_overflow_yet");
    n_tests++;
    if (bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL direct_stall_in_ready: got %0b", bus.in_ready);
    end
    send(DW'(99), 1'b0);
    chk(K_OV, 1, "drop_overflow");
    chk(K_IR, 0, "drop_in_ready");
    n_tests++;
    if (bus.overflow !== 1'b1) begin
        n_fail++;
        $display("FAIL direct_drop_overflow: got %0b", bus.overflow);
    end
    pulse_done();
    chk(K_FB, 0, "stall_release_fill_bank");
    chk(K_FR, 1, "stall_release_frame_ready");
    chk(K_IR, 1, "stall_release_in_ready");
    chk(K_OV, 1, "overflow_sticky");
    read(3'd0);
    chk(K_DOUT, 10, "bank1_addr0");
    read(3'd7);
    chk(K_DOUT, 17, "bank1_addr7");

    // Release bank 1 -> S_FILL; engine write now ignored
    pulse_done();
    chk(K_FR, 0, "release_frame_ready");
    chk(K_FB, 0, "release_fill_bank");
    eng_write(3'd4, 18'h12345);
    chk(K_DOUT, REV ? 32'd11 : 32'd14, "ignored_wr_cycle");
    step();
    chk(K_DOUT, REV ? 32'd11 : 32'd14, "ignored_wr_unchanged");

    // Reset mid-frame
    for (int i = 0; i < 4; i++) send(DW'(40 + i), 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk(K_FR, 0, "midrst_frame_ready");
    chk(K_OV, 0, "midrst_overflow");
    chk(K_IR, 1, "midrst_in_ready");
    chk(K_FB, 0, "midrst_fill_bank");
    for (int i = 0; i < 7; i++) send(DW'(50 + i), 1'b0);
    chk(K_FR, 0, "midrst_7_frame_ready");
    send(DW'(57), 1'b0);
    chk(K_FR, 1, "midrst_8_frame_ready");
    chk(K_FB, 1, "midrst_8_fill_bank");
    read(3'd0);
    chk(K_DOUT, 50, "midrst_addr0");

    // Last sample and frame_done together
    for (int i = 0; i < 7; i++) send(DW'(60 + i), 1'b0);
    send(DW'(67), 1'b1);
    chk(K_FB, 0, "simul_fill_bank");
    chk(K_FR, 1, "simul_frame_ready");
    chk(K_IR, 1, "simul_in_ready");
    chk(K_OV, 0, "simul_overflow");
    n_tests++;
    if (bus.fill_bank !== 1'b0) begin
        n_fail++;
        $display("FAIL direct_simul_fill_bank: got %0b", bus.fill_bank);
    end
    read(3'd7);
    chk(K_DOUT, 67, "simul_addr7");
    pulse_done();
    chk(K_FR, 0, "simul_was_busy");

    for (int i = 0; i < 10 && sb.size() > 0; i++) step();
    while (sb.size() > 0) begin
      chk_t c;
      c = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: never checked, expected %0h", c.name, c.exp);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_pingpong_ram.md
FFT_PINGPONG_RAM -- requirements
Module: fft_pingpong_ram

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 18, giving the sample word width in bits.
REQ-002 The block SHALL have parameter ADDR_BITS, default 10, giving log2 of frame depth (DEPTH = 2**ADDR_BITS); each of the two banks holds DEPTH words.
REQ-003 Port Clk  input  1  the single clock; all logic SHALL be on posedge Clk.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port in_valid  input  1  sample strobe on the acquisition side.
REQ-006 Port in_data  input  DATA_WIDTH  sample word, accepted when in_valid && in_ready.
REQ-007 Port in_ready  output  1  the fill bank can accept a sample.
REQ-008 Port frame_ready  output  1  a complete frame is held in the compute bank.
REQ-009 Port frame_done  input  1  single-cycle pulse; the FFT engine releases the compute bank.
REQ-010 Port addrB  input  ADDR_BITS  engine-side address into the compute bank.
REQ-011 Port DinB  input  DATA_WIDTH  engine-side write data.
REQ-012 Port write_enableB  input  1  engine-side write strobe.
REQ-013 Port DoutB  output  DATA_WIDTH  engine-side registered read data.
REQ-014 Port fill_bank  output  1  index of the bank being filled; the compute bank is ~fill_bank.
REQ-015 Port overflow  output  1  sticky flag, set when a sample is dropped.

Function
REQ-016 The FSM SHALL have three states: S_FILL (no frame held), S_FILL_BUSY (frame held, filling the other bank), and S_STALL (both banks full).
REQ-017 Accepted samples SHALL be written to the fill bank at wr_ptr, with wr_ptr incrementing by 1 per accepted sample.
- wr_ptr SHALL wrap from DEPTH-1 to 0.
- "last" means accepting a sample when wr_ptr == DEPTH-1.
REQ-018 in_ready SHALL be 1 in S_FILL and S_FILL_BUSY, and 0 in S_STALL.
REQ-019 S_FILL transitions:
- on last: fill_bank toggles, frame_ready becomes 1, next state S_FILL_BUSY.
- frame_done SHALL be ignored.
REQ-020 S_FILL_BUSY transitions:
- frame_done without last: frame_ready becomes 0, next state S_FILL.
- last without frame_done: next state S_STALL; fill_bank is held.
- last and frame_done in the same cycle: fill_bank toggles, frame_ready stays 1, state stays S_FILL_BUSY.
REQ-021 S_STALL transitions:
- in_valid SHALL drop the sample, set overflow, and leave memory and wr_ptr unchanged.
- frame_done: fill_bank toggles, frame_ready stays 1, next state S_FILL_BUSY.
REQ-022 Port B SHALL address the compute bank as selected before the clock edge, including on a swap cycle.
REQ-023 Port B reads SHALL have 1-cycle latency: DoutB <= mem[~fill_bank][addrB] every cycle.
- Read-before-write SHALL apply when write_enableB targets the same address.
REQ-024 write_enableB SHALL take effect only while frame_ready == 1; otherwise it SHALL be ignored.
REQ-025 Port A and port B SHALL never address the same bank in the same cycle, so no collision arbitration is required.
REQ-026 overflow SHALL stay 1 until reset.

Reset
REQ-027 On reset the block SHALL set:
- state = S_FILL;
- wr_ptr = 0, fill_bank = 0;
- frame_ready = 0, overflow = 0, DoutB = 0.
- in_ready SHALL be 1 in the cycle after reset deasserts.
REQ-028 Memory contents SHALL NOT be cleared by reset.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame and any held frame; reset SHALL take priority over all other inputs in that cycle.

Configuration
REQ-030 With macro BIT_REVERSE_WR_EN defined, port A SHALL write at the bit-reversed value of wr_ptr (ADDR_BITS wide); wr_ptr counting, last detection and the FSM are unchanged.
REQ-031 With BIT_REVERSE_WR_EN undefined, port A SHALL write at wr_ptr in natural order.

Verification (ADDR_BITS=3, DATA_WIDTH=18)
REQ-032 Fill: reset, then 8 samples 0..7 with in_valid=1 -> frame_ready=1 and fill_bank=1 after the 8th; reading addrB=5 gives DoutB=5 one cycle later (=5 at addrB=5 also in BIT_REVERSE_WR_EN build, since rev(5)=5; addrB=1 gives 4 there).
REQ-033 Stall: fill 16 samples with no frame_done -> in_ready=0 after the 16th; 17th sample dropped, overflow=1; frame_done -> fill_bank toggles, frame_ready=1, in_ready=1.
REQ-034 Simultaneous: frame_done in the same cycle as the 16th sample -> state S_FILL_BUSY, frame_ready stays 1, fill_bank toggles, overflow=0.
REQ-035 Engine write: with frame_ready=1, write DinB=0x3FFFF to addrB=2, read addrB=2 -> DoutB=0x3FFFF; same write with frame_ready=0 -> memory unchanged.
REQ-036 Same-address read/write: write DinB=0x00AA at addrB=3 while reading addrB=3 (old value 3) -> DoutB=3, then DoutB=0x00AA on the next read.
REQ-037 Reset mid-frame: reset after 4 samples -> wr_ptr=0, frame_ready=0, overflow=0, in_ready=1; 8 further samples are needed to raise frame_ready.
